// File: rtl/hs_mem_responder.sv
// hs_mem_responder: clocked responder for the core's four-phase bundled-data
// memory channel. Synchronises req, samples we/addr/wdata, services a read
// or write against an internal word array after LATENCY cycles, then acks.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   req_i      request from core (asynchronous to clk)
//   we_i       1=write, 0=read (bundled with req_i)
//   addr_i     word address (bundled)
//   wdata_i    write data (bundled)
//   ack_o      registered acknowledge
//   rdata_o    read data, valid while ack_o=1 after a read
//   err_o      1 while ack_o=1 when the address was out of range
//   stat_rd_o  completed reads, saturating (HS_MEM_STATS_EN only)
//   stat_wr_o  completed writes, saturating (HS_MEM_STATS_EN only)
//
// Optional feature macro: HS_MEM_STATS_EN (adds the access counters).

module hs_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 256,
    parameter int LATENCY     = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              ack_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o
`ifdef HS_MEM_STATS_EN
    ,
    output logic [15:0]       stat_rd_o,
    output logic [15:0]       stat_wr_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_e;

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [3:0]             cnt_q;
    logic                   we_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [DATA_W-1:0]      wdata_q;
    logic                   ack_q;
    logic                   err_q;
    logic [DATA_W-1:0]      rdata_q;

    logic [DATA_W-1:0]      mem [DEPTH];

    logic req_s;
    logic in_rng;
    logic access;
    logic mem_we;

    assign req_s  = sync_q[SYNC_STAGES-1];
    assign in_rng = (32'(addr_q) < 32'(DEPTH));

    // The access edge: last BUSY cycle with req still held. A req drop
    // on that same edge is an abort and takes priority.
    assign access = (state_q == BUSY) && (cnt_q == 4'd0) && req_s;
    assign mem_we = access && we_q && in_rng;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_i};
        end
    end

    // Array is kept out of the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= wdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_s) begin
                        we_q    <= we_i;
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        cnt_q   <= 4'(LATENCY - 1);
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (!req_s) begin
                        state_q <= IDLE;
                    end else if (cnt_q == 4'd0) begin
                        if (!we_q) begin
                            rdata_q <= in_rng ? mem[addr_q] : '0;
                        end
                        err_q   <= !in_rng;
                        ack_q   <= 1'b1;
                        state_q <= ACK;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ACK: begin
                    if (!req_s) begin
                        ack_q   <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack_o   = ack_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;

`ifdef HS_MEM_STATS_EN
    logic [15:0] rd_cnt_q;
    logic [15:0] wr_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (access) begin
            if (we_q && wr_cnt_q != 16'hFFFF) begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
            if (!we_q && rd_cnt_q != 16'hFFFF) begin
                rd_cnt_q <= rd_cnt_q + 16'd1;
            end
        end
    end

    assign stat_rd_o = rd_cnt_q;
    assign stat_wr_o = wr_cnt_q;
`endif

endmodule
